// File: rtl/universal_register.sv
// universal_register: DATA_WIDTH-bit register with load, shift, rotate and count modes,
// plus registered carry and combinational zero/serial-out flags.
module universal_register #(
    parameter int DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  ureg_reset_n,
    input  logic [DATA_WIDTH-1:0] ureg_in,
    input  logic                  ureg_en,
    input  logic [2:0]            ureg_mode,
    input  logic                  ureg_serial_in,
    output logic [DATA_WIDTH-1:0] ureg_out,
    output logic                  ureg_carry,
    output logic                  ureg_zero,
    output logic                  ureg_serial_out
);
    localparam logic [DATA_WIDTH:0] ONE = 1;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] q_next;
    logic                  c_next;
    // carry/borrow is the MSB of the W+1 bit result
    assign sum  = {1'b0, ureg_out} + ONE;
    assign diff = {1'b0, ureg_out} - ONE;
    always_comb begin
        q_next = ureg_out;
        c_next = ureg_carry;
        case (ureg_mode)
            3'b001: {c_next, q_next} = {1'b0, ureg_in};
            3'b010: {c_next, q_next} = {ureg_out, ureg_serial_in};
            3'b011: {q_next, c_next} = {ureg_serial_in, ureg_out};
            3'b100: {c_next, q_next} = {ureg_out, ureg_out[DATA_WIDTH-1]};
            3'b101: {q_next, c_next} = {ureg_out[DATA_WIDTH-1], ureg_out};
            3'b110: {c_next, q_next} = sum;
            3'b111: {c_next, q_next} = diff;
            default: ;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!ureg_reset_n) begin
            ureg_out   <= RESET_VALUE;
            ureg_carry <= 1'b0;
        end else if (ureg_en) begin
            ureg_out   <= q_next;
            ureg_carry <= c_next;
        end
    end
    assign ureg_zero       = ureg_out == '0;
    assign ureg_serial_out = (ureg_mode == 3'b010 || ureg_mode == 3'b100) ? ureg_out[DATA_WIDTH-1] : ureg_out[0];
endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: vector table, wrap/reset corner sequences and a random run
// against an arithmetic reference model; second instance covers an 8-bit build.
module tb_universal_register;
    logic        clk = 1'b0;
    logic        rn, en, sin;
    logic [2:0]  m;
    logic [15:0] din;
    logic [15:0] q;
    logic        c, z, so;
    logic        rn8, en8, sin8;
    logic [2:0]  m8;
    logic [7:0]  din8;
    logic [7:0]  q8;
    logic        c8, z8, so8;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    universal_register dut (
        .clock(clk), .ureg_reset_n(rn), .ureg_in(din), .ureg_en(en), .ureg_mode(m),
        .ureg_serial_in(sin), .ureg_out(q), .ureg_carry(c), .ureg_zero(z), .ureg_serial_out(so)
    );

    universal_register #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clock(clk), .ureg_reset_n(rn8), .ureg_in(din8), .ureg_en(en8), .ureg_mode(m8),
        .ureg_serial_in(sin8), .ureg_out(q8), .ureg_carry(c8), .ureg_zero(z8), .ureg_serial_out(so8)
    );

    typedef struct {
        bit          rn;
        bit          en;
        logic [2:0]  m;
        logic [15:0] din;
        bit          sin;
        logic [15:0] q;
        bit          c;
        bit          z;
        bit          so;
    } vec_t;

    vec_t vecs [28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: returns {carry, Q} after one edge, using plain integer arithmetic
    function automatic logic [32:0] step(input longint qv, input bit cv, input bit r, input bit e,
                                         input int md, input longint d, input bit s, input int w,
                                         input longint rv);
        longint mm = longint'(1) << w;
        longint h = mm / 2;
        if (!r) return {1'b0, 32'(rv)};
        if (!e || md == 0) return {cv, 32'(qv)};
        case (md)
            1: return {1'b0, 32'(d)};
            2: return {qv >= h, 32'((qv * 2 + longint'(s)) % mm)};
            3: return {qv % 2 == 1, 32'(qv / 2 + longint'(s) * h)};
            4: return {qv >= h, 32'((qv * 2) % mm + qv / h)};
            5: return {qv % 2 == 1, 32'(qv / 2 + (qv >= h ? h : 0))};
            6: return {qv == mm - 1, 32'((qv + 1) % mm)};
            default: return {qv == 0, 32'((qv + mm - 1) % mm)};
        endcase
    endfunction

    initial begin
        logic [32:0] nx;
        longint mq;
        bit mc;
        vecs[0]  = '{0, 1, 3'd1, 16'h1234, 0, 16'h0000, 0, 1, 0};
        vecs[1]  = '{1, 1, 3'd1, 16'h0032, 0, 16'h0032, 0, 0, 0};
        vecs[2]  = '{1, 0, 3'd1, 16'hFD92, 0, 16'h0032, 0, 0, 0};
        vecs[3]  = '{1, 0, 3'd1, 16'hFD92, 0, 16'h0032, 0, 0, 0};
        vecs[4]  = '{1, 0, 3'd1, 16'hFD92, 0, 16'h0032, 0, 0, 0};
        vecs[5]  = '{1, 1, 3'd1, 16'hFD92, 0, 16'hFD92, 0, 0, 0};
        vecs[6]  = '{1, 1, 3'd1, 16'h8001, 0, 16'h8001, 0, 0, 1};
        vecs[7]  = '{1, 1, 3'd2, 16'h5555, 0, 16'h0002, 1, 0, 0};
        vecs[8]  = '{1, 1, 3'd3, 16'h5555, 1, 16'h8001, 0, 0, 1};
        vecs[9]  = '{1, 1, 3'd1, 16'h8004, 0, 16'h8004, 0, 0, 0};
        vecs[10] = '{1, 1, 3'd5, 16'h0000, 1, 16'hC002, 0, 0, 0};
        vecs[11] = '{1, 1, 3'd1, 16'h8001, 0, 16'h8001, 0, 0, 1};
        vecs[12] = '{1, 1, 3'd4, 16'h0000, 0, 16'h0003, 1, 0, 0};
        vecs[13] = '{1, 1, 3'd1, 16'hFFFF, 0, 16'hFFFF, 0, 0, 1};
        vecs[14] = '{1, 1, 3'd6, 16'h0000, 0, 16'h0000, 1, 1, 0};
        vecs[15] = '{1, 1, 3'd6, 16'h0000, 0, 16'h0001, 0, 0, 1};
        vecs[16] = '{1, 1, 3'd7, 16'h0000, 0, 16'h0000, 0, 1, 0};
        vecs[17] = '{1, 1, 3'd7, 16'h0000, 0, 16'hFFFF, 1, 0, 1};
        vecs[18] = '{1, 1, 3'd1, 16'h00FE, 0, 16'h00FE, 0, 0, 0};
        vecs[19] = '{1, 1, 3'd6, 16'h0000, 0, 16'h00FF, 0, 0, 1};
        vecs[20] = '{0, 1, 3'd6, 16'h0000, 0, 16'h0000, 0, 1, 0};
        vecs[21] = '{1, 1, 3'd6, 16'h0000, 0, 16'h0001, 0, 0, 1};
        vecs[22] = '{1, 1, 3'd0, 16'hABCD, 1, 16'h0001, 0, 0, 1};
        vecs[23] = '{1, 1, 3'd7, 16'h0000, 0, 16'h0000, 0, 1, 0};
        vecs[24] = '{1, 1, 3'd7, 16'h0000, 0, 16'hFFFF, 1, 0, 1};
        vecs[25] = '{1, 1, 3'd0, 16'h1111, 0, 16'hFFFF, 1, 0, 1};
        vecs[26] = '{1, 0, 3'd6, 16'h0000, 0, 16'hFFFF, 1, 0, 1};
        vecs[27] = '{1, 0, 3'd2, 16'h0000, 0, 16'hFFFF, 1, 0, 1};
        rn8 = 1'b0; en8 = 1'b0; m8 = 3'd0; din8 = 8'h00; sin8 = 1'b0;
        for (int i = 0; i < 28; i++) begin
            rn = vecs[i].rn; en = vecs[i].en; m = vecs[i].m; din = vecs[i].din; sin = vecs[i].sin;
            tick();
            check($sformatf("vec%0d out", i), 32'(q), 32'(vecs[i].q));
            check($sformatf("vec%0d carry", i), 32'(c), 32'(vecs[i].c));
            check($sformatf("vec%0d zero", i), 32'(z), 32'(vecs[i].z));
            check($sformatf("vec%0d serial_out", i), 32'(so), 32'(vecs[i].so));
        end
        // 8-bit build: reset value, increment wrap, shift-out of MSB
        en = 1'b0;
        rn8 = 1'b0; en8 = 1'b1; m8 = 3'd1; din8 = 8'h3C;
        tick();
        check("w8 reset out", 32'(q8), 32'h000000A5);
        check("w8 reset carry", 32'(c8), 32'h0);
        rn8 = 1'b1; din8 = 8'hFF;
        tick();
        m8 = 3'd6;
        tick();
        check("w8 inc wrap out", 32'(q8), 32'h0);
        check("w8 inc wrap carry", 32'(c8), 32'h1);
        check("w8 inc wrap zero", 32'(z8), 32'h1);
        m8 = 3'd1; din8 = 8'h80;
        tick();
        m8 = 3'd2; sin8 = 1'b0;
        tick();
        check("w8 shl out", 32'(q8), 32'h0);
        check("w8 shl carry", 32'(c8), 32'h1);
        check("w8 shl serial_out", 32'(so8), 32'h0);
        // Random run against the model, starting from the table's final state
        mq = 64'hFFFF;
        mc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rn = $urandom_range(0, 19) != 0;
            en = $urandom_range(0, 4) != 0;
            m = 3'($urandom_range(0, 7));
            din = 16'($urandom);
            sin = 1'($urandom);
            nx = step(mq, mc, rn, en, int'(m), longint'(din), sin, 16, 0);
            tick();
            mq = longint'(nx[15:0]);
            mc = nx[32];
            check("rand out", 32'(q), 32'(mq));
            check("rand carry", 32'(c), 32'(mc));
            check("rand zero", 32'(z), 32'(mq == 0));
            check("rand serial_out", 32'(so), 32'((m == 3'd2 || m == 3'd4) ? mq >= 32768 : mq % 2 == 1));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
